hazard_stall_controller: RTL

Parametrised hazard/stall controller for the 5-stage RISC-V pipeline. It generalises single-cycle load-use detection in four ways:
- configurable load-to-use latency,
- multi-cycle EX operations (mul/div),
- global memory-wait freeze,
- taken-branch flush.

It sits beside the ID stage and drives the PC, IF/ID and ID/EX write enables, the bubble/flush controls and a stall-cycle statistic counter.

---
 rtl/hazard_stall_if.sv | 43 ++++
 rtl/hazard_stall_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_if.sv
// Handshake bundle between the ID-stage hazard/stall controller and the pipeline.
// The pipeline side (master) supplies the hazard inputs and consumes the enables.
// The controller side (slave) does the reverse.
interface hazard_stall_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;
    logic                  if_id_use_rs1;
    logic                  if_id_use_rs2;
    logic                  id_ex_multi;
    logic                  branch_taken;
    logic                  mem_wait;
    logic                  stat_clear;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_write;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  pipe_hold;
    logic                  busy;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_use_rs1, if_id_use_rs2, id_ex_multi, branch_taken,
               mem_wait, stat_clear,
        input  pc_write, if_id_write, id_ex_write, id_ex_bubble,
               if_id_flush, pipe_hold, busy, stall_count
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
               if_id_use_rs1, if_id_use_rs2, id_ex_multi, branch_taken,
               mem_wait, stat_clear,
        output pc_write, if_id_write, id_ex_write, id_ex_bubble,
               if_id_flush, pipe_hold, busy, stall_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for the 5-stage RISC-V pipeline.
// Handles load-use stalls of configurable length, multi-cycle EX occupancy,
// a global memory-wait freeze and taken-branch flushes, and counts stall cycles.
// The interface parameters must match REG_ADDR_W and CNT_W of this module.
module hazard_stall_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MULTI_LAT  = 4,
    parameter int CNT_W      = 16,
    parameter bit X0_HAZARD  = 1'b0
) (
    input logic          clk,
    input logic          rst,
    hazard_stall_if.slave bus
);
    localparam int MAX_LAT = (LOAD_LAT > MULTI_LAT) ? LOAD_LAT : MULTI_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] MULTI_INIT = CW'(MULTI_LAT - 2);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_WAIT  = 2'd1,
        MULTI_BUSY = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;

    logic dep;
    logic pc_write, if_id_write, id_ex_write;
    logic id_ex_bubble, if_id_flush, pipe_hold;

    // Load-use dependency between the load in EX and the sources read in ID.
    assign dep = bus.id_ex_mem_read
               && (X0_HAZARD || (bus.id_ex_rd != '0))
               && ((bus.if_id_use_rs1 && (bus.if_id_rs1 == bus.id_ex_rd))
                || (bus.if_id_use_rs2 && (bus.if_id_rs2 == bus.id_ex_rd)));

    // Priority-ordered output decode and next-state/counter selection.
    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pipe_hold    = 1'b0;

        if (rst) begin
            // Detection is masked; outputs keep their free-running defaults.
            state_d = RUN;
            cnt_d   = '0;
        end else if (bus.mem_wait) begin
            // Whole pipe frozen; state and countdown hold.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            pipe_hold   = 1'b1;
        end else begin
            case (state_q)
                MULTI_BUSY: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    cnt_d       = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = RUN;
                end
                LOAD_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = RUN;
                end
                RUN: begin
                    if (bus.id_ex_multi) begin
                        // A multi-cycle op is never a branch, so branch_taken is not looked at.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        if (MULTI_LAT > 2) begin
                            state_d = MULTI_BUSY;
                            cnt_d   = MULTI_INIT;
                        end
                    end else if (bus.branch_taken) begin
                        // The ID instruction is squashed, so any dependency it has is moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (dep) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LOAD_WAIT;
                            cnt_d   = LOAD_INIT;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and countdown registers.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values and updates together.
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating stall-cycle statistic; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.stat_clear) begin
            stall_q <= '0;
        end else if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.id_ex_write  = id_ex_write;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.pipe_hold    = pipe_hold;
    assign bus.busy         = !rst && (state_q != RUN);
    assign bus.stall_count  = stall_q;
endmodule
